command_sender: RTL and testbench

Transmit end of the command byte protocol consumed by the pipeline head's command input. Takes one parallel command request (opcode plus up to MAX_PAYLOAD_BYTES of payload) and serializes it onto the byte stream. It then collects the single status byte returned on the response stream and hands it back to the requester, with a timeout for a missing response. Used by on-chip scene/model generators and the host bridge to drive the pipeline head.

---
 rtl/command_sender.sv | 134 +++++++++++++
 tb/tb_command_sender.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/command_sender.sv
// Serializes one command request (opcode + payload) onto a byte stream,
// then returns the single response byte, or 8'hFF when the response times out.
module command_sender #(
  parameter int MAX_PAYLOAD_BYTES = 48,
  parameter int TIMEOUT_CYCLES    = 1024,
  localparam int LEN_W = $clog2(MAX_PAYLOAD_BYTES + 1),
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [7:0]                     req_opcode,
  input  logic [LEN_W-1:0]               req_length,
  input  logic [8*MAX_PAYLOAD_BYTES-1:0] req_payload,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_data,
  input  logic                           rx_valid,
  output logic                           rx_ready,
  input  logic [7:0]                     rx_data,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [7:0]                     resp_status,
  output logic                           resp_timeout,
  output logic [7:0]                     stray_count,
  output logic                           busy
);

  typedef enum logic [2:0] {IDLE, SEND_OP, SEND_PAYLOAD, WAIT_RESP, RESP} state_t;

  state_t           state, next_state;
  logic             alive;
  logic [LEN_W-1:0] len_q, idx, nxt_idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       pay_q [MAX_PAYLOAD_BYTES];

  logic tx_fire, rx_fire, req_fire, resp_fire;
  logic last_tx, final_fire, resp_rx, stray_rx, timeout_hit;

  assign tx_fire    = tx_valid && tx_ready;
  assign rx_fire    = rx_valid && rx_ready;
  assign req_fire   = req_valid && req_ready;
  assign resp_fire  = resp_valid && resp_ready;
  assign nxt_idx    = idx + 1'b1;
  assign final_fire = tx_fire && last_tx;
  // A byte arriving with the final tx handshake is the response, not a stray.
  assign resp_rx    = rx_fire && (final_fire || state == WAIT_RESP);
  assign stray_rx   = rx_fire && !resp_rx && (state != WAIT_RESP) && (state != RESP);
  assign timeout_hit = (state == WAIT_RESP) && !rx_fire &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    last_tx = 1'b0;
    if (state == SEND_OP)           last_tx = (len_q == '0);
    else if (state == SEND_PAYLOAD) last_tx = (idx == len_q - 1'b1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= next_state;
      alive <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:         if (req_fire) next_state = SEND_OP;
      SEND_OP:      if (tx_fire) begin
                      if (!last_tx)     next_state = SEND_PAYLOAD;
                      else if (rx_fire) next_state = RESP;
                      else              next_state = WAIT_RESP;
                    end
      SEND_PAYLOAD: if (final_fire) next_state = rx_fire ? RESP : WAIT_RESP;
      WAIT_RESP:    if (rx_fire || timeout_hit) next_state = RESP;
      RESP:         if (resp_fire) next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // The alive flag keeps the ready outputs low until the first edge after reset.
  always_comb begin
    req_ready  = alive && (state == IDLE);
    tx_valid   = (state == SEND_OP) || (state == SEND_PAYLOAD);
    rx_ready   = alive && (state != RESP);
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) pay_q[k] <= req_payload[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q        <= '0;
      idx          <= '0;
      cnt          <= '0;
      tx_data      <= 8'h00;
      resp_status  <= 8'h00;
      resp_timeout <= 1'b0;
      stray_count  <= 8'h00;
    end else begin
      if (req_fire) begin
        len_q   <= (req_length > LEN_W'(MAX_PAYLOAD_BYTES)) ? LEN_W'(MAX_PAYLOAD_BYTES) : req_length;
        idx     <= '0;
        tx_data <= req_opcode;
      end
      // tx_data only moves on a handshake, so it holds steady under backpressure.
      if (state == SEND_OP && tx_fire && !last_tx) tx_data <= pay_q[0];
      if (state == SEND_PAYLOAD && tx_fire) begin
        idx <= nxt_idx;
        if (!last_tx) tx_data <= pay_q[nxt_idx];
      end
      if (state != WAIT_RESP) cnt <= '0;
      else if (!rx_fire)      cnt <= cnt + 1'b1;
      if (resp_rx) begin
        resp_status  <= rx_data;
        resp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        resp_status  <= 8'hFF;
        resp_timeout <= 1'b1;
      end
      if (stray_rx && stray_count != 8'hFF) stray_count <= stray_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_command_sender.sv
// Self-checking bench for command_sender: directed scenarios plus random
// commands checked against a byte-queue reference model.
module tb_command_sender;
  localparam int MAXP  = 48;
  localparam int TO    = 16;
  localparam int LEN_W = $clog2(MAXP + 1);

  logic              clk = 1'b0;
  logic              rstn;
  logic              req_valid, req_ready;
  logic [7:0]        req_opcode;
  logic [LEN_W-1:0]  req_length;
  logic [8*MAXP-1:0] req_payload;
  logic              tx_valid, tx_ready;
  logic [7:0]        tx_data;
  logic              rx_valid, rx_ready;
  logic [7:0]        rx_data;
  logic              resp_valid, resp_ready;
  logic [7:0]        resp_status;
  logic              resp_timeout;
  logic [7:0]        stray_count;
  logic              busy;

  int tests = 0;
  int fails = 0;
  int stray_exp = 0;

  command_sender #(.MAX_PAYLOAD_BYTES(MAXP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_length(req_length), .req_payload(req_payload),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_timeout(resp_timeout), .stray_count(stray_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string when);
    check_output({when, " tx_valid"}, tx_valid, 0);
    check_output({when, " tx_data"}, tx_data, 0);
    check_output({when, " rx_ready"}, rx_ready, 0);
    check_output({when, " resp_valid"}, resp_valid, 0);
    check_output({when, " resp_status"}, resp_status, 0);
    check_output({when, " resp_timeout"}, resp_timeout, 0);
    check_output({when, " stray_count"}, stray_count, 0);
    check_output({when, " busy"}, busy, 0);
    check_output({when, " req_ready"}, req_ready, 0);
  endtask

  function automatic logic [8*MAXP-1:0] rand_payload();
    logic [8*MAXP-1:0] p;
    for (int k = 0; k < MAXP; k++) p[8*k +: 8] = 8'($urandom);
    return p;
  endfunction

  // rx_at: -2 = response rides on the final tx handshake, -1 = never respond,
  // otherwise the response arrives that many cycles into the wait.
  task automatic apply_stimulus(input logic [7:0] op, input int len, input logic [8*MAXP-1:0] pay,
                                input int ready_pct, input int rx_at, input logic [7:0] rx_byte,
                                input bit strays);
    logic [7:0] q[$];
    int n, wait_cnt, guard, hold;
    bit done;
    logic [7:0] exp_status;
    logic exp_to;
    n = (len > MAXP) ? MAXP : len;
    wait_cnt = 0; guard = 0; done = 0; exp_status = 8'h00; exp_to = 1'b0;
    q.push_back(op);
    for (int k = 0; k < n; k++) q.push_back(pay[8*k +: 8]);

    req_valid = 1'b1; req_opcode = op; req_length = LEN_W'(len); req_payload = pay;
    #1;
    check_output("req_ready idle", req_ready, 1);
    step();
    req_valid = 1'b0; req_opcode = 8'($urandom); req_payload = rand_payload();

    while (!done && guard < 2000) begin
      guard++;
      tx_ready = ($urandom_range(99) < ready_pct);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      if (q.size() > 0) begin
        if (q.size() == 1 && tx_ready) begin
          if (rx_at == -2) begin rx_valid = 1'b1; rx_data = rx_byte; end
        end else if (strays && $urandom_range(9) == 0) begin
          rx_valid = 1'b1;
        end
      end else if (wait_cnt == rx_at) begin
        rx_valid = 1'b1; rx_data = rx_byte;
      end
      #1;
      check_output("busy active", busy, 1);
      check_output("resp_valid early", resp_valid, 0);
      check_output("rx_ready active", rx_ready, 1);
      check_output("tx_valid", tx_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) check_output("tx_data order", tx_data, q[0]);
      if (q.size() > 0) begin
        if (tx_ready) begin
          if (q.size() == 1 && rx_valid) begin done = 1; exp_status = rx_data; exp_to = 1'b0; end
          void'(q.pop_front());
        end
        if (rx_valid && !done && stray_exp < 255) stray_exp++;
      end else begin
        if (rx_valid) begin done = 1; exp_status = rx_byte; exp_to = 1'b0; end
        else if (wait_cnt == TO - 1) begin done = 1; exp_status = 8'hFF; exp_to = 1'b1; end
        wait_cnt++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++; fails++;
      $error("[TB] FAIL cmd_budget: observed no response after %0d cycles required completion", guard);
    end

    tx_ready = 1'b0;
    rx_valid = 1'b0;
    check_output("resp_valid", resp_valid, 1);
    check_output("resp_status", resp_status, exp_status);
    check_output("resp_timeout", resp_timeout, exp_to);
    check_output("rx_ready in resp", rx_ready, 0);
    check_output("tx_valid in resp", tx_valid, 0);
    hold = $urandom_range(2);
    repeat (hold) begin
      rx_valid = 1'($urandom_range(1));
      resp_ready = 1'b0;
      step();
      check_output("resp hold valid", resp_valid, 1);
      check_output("resp hold status", resp_status, exp_status);
    end
    rx_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check_output("resp_valid after ack", resp_valid, 0);
    check_output("req_ready after ack", req_ready, 1);
    check_output("busy after ack", busy, 0);
    check_output("stray_count", stray_count, stray_exp);
  endtask

  initial begin
    logic [8*MAXP-1:0] p;
    int len, rx_at, r;
    rstn = 1'b0; req_valid = 1'b0; req_opcode = 8'h00; req_length = '0; req_payload = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; resp_ready = 1'b0;
    #3;
    check_reset_values("reset");
    #9;
    rstn = 1'b1;
    #1;
    check_output("req_ready before edge", req_ready, 0);
    step();
    check_output("req_ready after edge", req_ready, 1);

    // Basic 3-byte command, response two cycles into the wait.
    p = '0; p[7:0] = 8'hAA; p[15:8] = 8'hBB; p[23:16] = 8'hCC;
    apply_stimulus(8'h01, 3, p, 100, 2, 8'h00, 1'b0);

    // Zero-length command with the response on the opcode handshake.
    apply_stimulus(8'h42, 0, rand_payload(), 100, -2, 8'h5A, 1'b0);

    // Full payload under 50% backpressure.
    apply_stimulus(8'h7E, MAXP, rand_payload(), 50, 3, 8'h33, 1'b0);

    // Timeout, then a response on the last cycle before expiry.
    apply_stimulus(8'h10, 2, rand_payload(), 100, -1, 8'h00, 1'b0);
    apply_stimulus(8'h11, 2, rand_payload(), 100, TO - 1, 8'h77, 1'b0);

    // Flood of unsolicited bytes while idle.
    for (int i = 0; i < 300; i++) begin
      rx_valid = 1'b1; rx_data = 8'($urandom);
      #1;
      check_output("rx_ready idle", rx_ready, 1);
      step();
      if (stray_exp < 255) stray_exp++;
    end
    rx_valid = 1'b0;
    check_output("stray saturate", stray_count, 255);
    apply_stimulus(8'h20, 4, rand_payload(), 80, 1, 8'h9C, 1'b0);

    // Over-length request is clamped.
    apply_stimulus(8'h30, MAXP + 5, rand_payload(), 100, 0, 8'h01, 1'b0);

    // Reset mid-payload abandons the command.
    req_valid = 1'b1; req_opcode = 8'h55; req_length = LEN_W'(10); req_payload = rand_payload();
    step();
    req_valid = 1'b0; tx_ready = 1'b1;
    repeat (4) step();
    check_output("mid-cmd tx_valid", tx_valid, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_values("async reset");
    tx_ready = 1'b0;
    stray_exp = 0;
    step();
    rstn = 1'b1;
    #1;
    check_output("req_ready post reset", req_ready, 0);
    step();
    check_output("req_ready post reset edge", req_ready, 1);
    p = rand_payload();
    apply_stimulus(8'h66, 5, p, 100, 4, 8'hE1, 1'b0);

    // Random commands with backpressure, strays and mixed response timing.
    for (int i = 0; i < 15; i++) begin
      len = $urandom_range(0, MAXP + 5);
      r = $urandom_range(0, 5);
      if (r == 0)      rx_at = -2;
      else if (r == 1) rx_at = -1;
      else             rx_at = $urandom_range(0, TO + 2);
      apply_stimulus(8'($urandom), len, rand_payload(), $urandom_range(30, 100), rx_at,
                     8'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
